// File: rtl/imem_port_arbiter.sv
// ----------------------------------------------------------------------------
// imem_port_arbiter
//
// Purpose:
//   Shares the single instruction-memory RAM port between the core fetch stage
//   (read-only) and the program loader/debug port (read/write). The RAM has a
//   1-cycle registered read latency, so the read response is routed back to
//   whichever requester issued the read on the previous cycle.
//
//   The loader has priority, but a streak counter limits it to LD_BURST_MAX
//   consecutive grants while fetch is waiting. Then fetch gets one slot.
//   A lock mode (i_ld_lock) gives the loader exclusive ownership for program
//   download. While locked, fetch is refused and o_core_stall is high.
//
// Ports:
//   i_clk, i_rst_n                     clock, async active-low reset
//   i_if_req/i_if_addr                 fetch read request and byte address
//   o_if_gnt/o_if_rvalid/o_if_rdata    fetch grant and read response
//   i_ld_req/i_ld_we/i_ld_be           loader request, write flag, byte enables
//   i_ld_addr/i_ld_wdata               loader byte address and write data
//   o_ld_gnt/o_ld_rvalid/o_ld_rdata    loader grant and read response
//   o_ld_err                           pulse: misaligned loader write dropped
//   i_ld_lock/o_core_stall             exclusive-ownership request / status
//   o_mem_addr/o_mem_we/o_mem_size     RAM address, write enable, lane enables
//   o_mem_din/i_mem_dout               RAM write data / read data
// ----------------------------------------------------------------------------
module imem_port_arbiter #(
    parameter int unsigned IMEM_ADDR_WIDTH = 12,
    parameter int unsigned LD_BURST_MAX    = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    // Fetch port
    input  logic                       i_if_req,
    input  logic [IMEM_ADDR_WIDTH-1:0] i_if_addr,
    output logic                       o_if_gnt,
    output logic                       o_if_rvalid,
    output logic [31:0]                o_if_rdata,
    // Loader port
    input  logic                       i_ld_req,
    input  logic                       i_ld_we,
    input  logic [3:0]                 i_ld_be,
    input  logic [IMEM_ADDR_WIDTH-1:0] i_ld_addr,
    input  logic [31:0]                i_ld_wdata,
    output logic                       o_ld_gnt,
    output logic                       o_ld_rvalid,
    output logic [31:0]                o_ld_rdata,
    output logic                       o_ld_err,
    input  logic                       i_ld_lock,
    output logic                       o_core_stall,
    // RAM port
    output logic [IMEM_ADDR_WIDTH-1:0] o_mem_addr,
    output logic                       o_mem_we,
    output logic [3:0]                 o_mem_size,
    output logic [31:0]                o_mem_din,
    input  logic [31:0]                i_mem_dout
);

    // Wide enough to hold LD_BURST_MAX itself (the counter saturates there).
    localparam int unsigned STREAK_W = (LD_BURST_MAX < 2) ? 1 : $clog2(LD_BURST_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(LD_BURST_MAX);

    typedef enum logic [0:0] {
        StArb,
        StLocked
    } state_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e                       r_state;
    logic                         r_core_stall;
    logic [STREAK_W-1:0]          r_streak;
    logic                         r_rd_if;      // fetch owns the in-flight read
    logic                         r_rd_ld;      // loader owns the in-flight read
    logic                         r_ld_err;
    logic [IMEM_ADDR_WIDTH-1:0]   r_last_addr;  // RAM address held when idle

    // ------------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------------
    logic                         w_if_gnt;
    logic                         w_ld_gnt;
    logic [STREAK_W-1:0]          w_streak_d;
    logic                         w_ld_wr;
    logic                         w_ld_aligned;
    logic                         w_mem_we;
    logic                         w_ld_misalign;
    logic [IMEM_ADDR_WIDTH-1:0]   w_mem_addr;

    always_comb begin
        w_if_gnt   = 1'b0;
        w_ld_gnt   = 1'b0;
        w_streak_d = '0;
        if (r_state == StLocked) begin
            // Exclusive loader ownership; streak stays cleared.
            w_ld_gnt = i_ld_req;
        end else if (i_ld_req && i_if_req) begin
            if (r_streak < STREAK_MAX) begin
                w_ld_gnt   = 1'b1;
                w_streak_d = r_streak + STREAK_W'(1);
            end else begin
                // Fairness slot for fetch; streak restarts.
                w_if_gnt = 1'b1;
            end
        end else begin
            // Single requester: the streak only counts grants while fetch waits.
            w_ld_gnt = i_ld_req;
            w_if_gnt = i_if_req;
        end
    end

    assign w_ld_wr       = w_ld_gnt & i_ld_we;
    assign w_ld_aligned  = (i_ld_addr[1:0] == 2'b00);
    assign w_mem_we      = w_ld_wr & w_ld_aligned;
    // A misaligned write is still granted (so the loader moves on) but dropped.
    assign w_ld_misalign = w_ld_wr & ~w_ld_aligned;

    always_comb begin
        w_mem_addr = r_last_addr;
        if (w_ld_gnt) begin
            w_mem_addr = i_ld_addr;
        end else if (w_if_gnt) begin
            w_mem_addr = i_if_addr;
        end
    end

    // ------------------------------------------------------------------------
    // Registered state: FSM, streak, read ownership, error pulse
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StArb;
            r_core_stall <= 1'b0;
            r_streak     <= '0;
            r_rd_if      <= 1'b0;
            r_rd_ld      <= 1'b0;
            r_ld_err     <= 1'b0;
            r_last_addr  <= '0;
        end else begin
            unique case (r_state)
                StArb: begin
                    if (i_ld_lock) begin
                        r_state      <= StLocked;
                        r_core_stall <= 1'b1;
                    end
                end
                StLocked: begin
                    if (!i_ld_lock) begin
                        r_state      <= StArb;
                        r_core_stall <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= StArb;
                    r_core_stall <= 1'b0;
                end
            endcase
            r_streak    <= w_streak_d;
            r_rd_if     <= w_if_gnt;
            r_rd_ld     <= w_ld_gnt & ~i_ld_we;
            r_ld_err    <= w_ld_misalign;
            r_last_addr <= w_mem_addr;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_if_gnt     = w_if_gnt;
    assign o_ld_gnt     = w_ld_gnt;
    assign o_mem_addr   = w_mem_addr;
    assign o_mem_we     = w_mem_we;
    assign o_mem_size   = w_mem_we ? i_ld_be : 4'b0000;
    assign o_mem_din    = i_ld_wdata;

    assign o_if_rvalid  = r_rd_if;
    assign o_ld_rvalid  = r_rd_ld;
    assign o_if_rdata   = r_rd_if ? i_mem_dout : 32'h0;
    assign o_ld_rdata   = r_rd_ld ? i_mem_dout : 32'h0;
    assign o_ld_err     = r_ld_err;
    assign o_core_stall = r_core_stall;

    // Only one requester may own the RAM port in any cycle.
    a_one_grant: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(o_if_gnt && o_ld_gnt));

endmodule

// File: tb/tb_imem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_imem_port_arbiter
//
// Purpose:
//   Directed bench for imem_port_arbiter with a byte-lane RAM model that has
//   a 1-cycle registered read. Word i of the RAM starts as 0xC0DE0000 | i.
//   Arbitration patterns are table driven; the write, misaligned-write, lock
//   and reset corner cases are hand-written sequences.
// ----------------------------------------------------------------------------
module tb_imem_port_arbiter;

    localparam int unsigned AW    = 12;
    localparam int unsigned WORDS = 1 << (AW - 2);

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          ld_req;
    logic          ld_we;
    logic [3:0]    ld_be;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_wdata;
    logic          ld_gnt;
    logic          ld_rvalid;
    logic [31:0]   ld_rdata;
    logic          ld_err;
    logic          ld_lock;
    logic          core_stall;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [3:0]    mem_size;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout;

    int n_cmp;
    int n_err;

    imem_port_arbiter #(
        .IMEM_ADDR_WIDTH (AW),
        .LD_BURST_MAX    (4)
    ) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_if_req     (if_req),
        .i_if_addr    (if_addr),
        .o_if_gnt     (if_gnt),
        .o_if_rvalid  (if_rvalid),
        .o_if_rdata   (if_rdata),
        .i_ld_req     (ld_req),
        .i_ld_we      (ld_we),
        .i_ld_be      (ld_be),
        .i_ld_addr    (ld_addr),
        .i_ld_wdata   (ld_wdata),
        .o_ld_gnt     (ld_gnt),
        .o_ld_rvalid  (ld_rvalid),
        .o_ld_rdata   (ld_rdata),
        .o_ld_err     (ld_err),
        .i_ld_lock    (ld_lock),
        .o_core_stall (core_stall),
        .o_mem_addr   (mem_addr),
        .o_mem_we     (mem_we),
        .o_mem_size   (mem_size),
        .o_mem_din    (mem_din),
        .i_mem_dout   (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: byte-lane writes, registered word read (low address bits ignored).
    logic [31:0] ram [0:WORDS-1];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(WORDS); i++) ram[i] <= 32'hC0DE0000 | 32'(i);
        end else if (mem_we) begin
            if (mem_size[0]) ram[mem_addr[AW-1:2]][7:0]   <= mem_din[7:0];
            if (mem_size[1]) ram[mem_addr[AW-1:2]][15:8]  <= mem_din[15:8];
            if (mem_size[2]) ram[mem_addr[AW-1:2]][23:16] <= mem_din[23:16];
            if (mem_size[3]) ram[mem_addr[AW-1:2]][31:24] <= mem_din[31:24];
        end
        mem_dout <= ram[mem_addr[AW-1:2]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req   = 1'b0;
        if_addr  = '0;
        ld_req   = 1'b0;
        ld_we    = 1'b0;
        ld_be    = 4'b0000;
        ld_addr  = '0;
        ld_wdata = 32'h0;
        ld_lock  = 1'b0;
    endtask

    typedef struct {
        logic if_req;
        logic ld_req;
        logic exp_if_gnt;
        logic exp_ld_gnt;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic prev_if;
        logic prev_ld;
        n_cmp = 0;
        n_err = 0;

        // Arbitration table: loader reads 0x008, fetch reads 0x00C.
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0};

        // ---------------- Reset values ----------------
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        mid();
        check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        check("rst_ld_rvalid", 32'(ld_rvalid), 32'd0);
        check("rst_ld_err", 32'(ld_err), 32'd0);
        check("rst_core_stall", 32'(core_stall), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        tick();
        rst_n = 1'b1;

        // ---------------- Fetch-only back-to-back reads ----------------
        if_req = 1'b1; if_addr = 12'h000;
        mid();
        check("f0_gnt", 32'(if_gnt), 32'd1);
        check("f0_addr", 32'(mem_addr), 32'h000);
        tick();
        if_addr = 12'h004;
        mid();
        check("f1_gnt", 32'(if_gnt), 32'd1);
        check("f1_rvalid", 32'(if_rvalid), 32'd1);
        check("f1_rdata", if_rdata, 32'hC0DE0000);
        check("f1_ld_rvalid", 32'(ld_rvalid), 32'd0);
        tick();
        if_addr = 12'h006;
        mid();
        check("f2_rvalid", 32'(if_rvalid), 32'd1);
        check("f2_rdata", if_rdata, 32'hC0DE0001);
        tick();
        if_req = 1'b0;
        mid();
        check("f3_rvalid", 32'(if_rvalid), 32'd1);
        check("f3_rdata", if_rdata, 32'hC0DE0001);
        check("f3_ld_rvalid", 32'(ld_rvalid), 32'd0);
        check("f3_no_gnt", 32'(if_gnt), 32'd0);
        check("f3_addr_hold", 32'(mem_addr), 32'h006);
        tick();
        mid();
        check("f4_rvalid", 32'(if_rvalid), 32'd0);
        tick();

        // ---------------- Arbitration table ----------------
        prev_if = 1'b0;
        prev_ld = 1'b0;
        if_addr = 12'h00C;
        ld_addr = 12'h008;
        ld_we   = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if_req = vecs[i].if_req;
            ld_req = vecs[i].ld_req;
            mid();
            check($sformatf("arb%0d_if_gnt", i), 32'(if_gnt), 32'(vecs[i].exp_if_gnt));
            check($sformatf("arb%0d_ld_gnt", i), 32'(ld_gnt), 32'(vecs[i].exp_ld_gnt));
            check($sformatf("arb%0d_if_rvalid", i), 32'(if_rvalid), 32'(prev_if));
            check($sformatf("arb%0d_ld_rvalid", i), 32'(ld_rvalid), 32'(prev_ld));
            check($sformatf("arb%0d_mem_we", i), 32'(mem_we), 32'd0);
            if (vecs[i].exp_ld_gnt) check($sformatf("arb%0d_addr", i), 32'(mem_addr), 32'h008);
            if (vecs[i].exp_if_gnt) check($sformatf("arb%0d_addr", i), 32'(mem_addr), 32'h00C);
            if (prev_if) check($sformatf("arb%0d_if_rdata", i), if_rdata, 32'hC0DE0003);
            if (prev_ld) check($sformatf("arb%0d_ld_rdata", i), ld_rdata, 32'hC0DE0002);
            prev_if = vecs[i].exp_if_gnt;
            prev_ld = vecs[i].exp_ld_gnt;
            tick();
        end
        idle_inputs();

        // ---------------- Partial loader write then read ----------------
        ld_req = 1'b1; ld_we = 1'b1; ld_be = 4'b0011;
        ld_addr = 12'h010; ld_wdata = 32'hAABBCCDD;
        mid();
        check("wr_gnt", 32'(ld_gnt), 32'd1);
        check("wr_mem_we", 32'(mem_we), 32'd1);
        check("wr_mem_size", 32'(mem_size), 32'h3);
        check("wr_mem_din", mem_din, 32'hAABBCCDD);
        tick();
        ld_we = 1'b0; ld_be = 4'b0000;
        mid();
        check("wr_no_rvalid", 32'(ld_rvalid), 32'd0);
        check("rd_gnt", 32'(ld_gnt), 32'd1);
        tick();
        ld_req = 1'b0;
        mid();
        check("rd_rvalid", 32'(ld_rvalid), 32'd1);
        check("rd_rdata", ld_rdata, 32'hC0DECCDD);
        check("rd_if_rvalid", 32'(if_rvalid), 32'd0);
        check("rd_if_rdata", if_rdata, 32'h0);
        tick();

        // ---------------- Misaligned loader write ----------------
        ld_req = 1'b1; ld_we = 1'b1; ld_be = 4'b1111;
        ld_addr = 12'h013; ld_wdata = 32'h11223344;
        mid();
        check("mis_gnt", 32'(ld_gnt), 32'd1);
        check("mis_mem_we", 32'(mem_we), 32'd0);
        check("mis_mem_size", 32'(mem_size), 32'h0);
        check("mis_err_early", 32'(ld_err), 32'd0);
        tick();
        ld_req = 1'b0; ld_we = 1'b0; ld_be = 4'b0000;
        mid();
        check("mis_err", 32'(ld_err), 32'd1);
        check("mis_no_rvalid", 32'(ld_rvalid), 32'd0);
        tick();
        ld_req = 1'b1; ld_addr = 12'h010;
        mid();
        check("mis_err_once", 32'(ld_err), 32'd0);
        tick();
        ld_req = 1'b0;
        mid();
        check("mis_word_kept", ld_rdata, 32'hC0DECCDD);
        tick();

        // ---------------- Lock during an in-flight fetch ----------------
        if_req = 1'b1; if_addr = 12'h004; ld_lock = 1'b1;
        mid();
        check("lk_if_gnt", 32'(if_gnt), 32'd1);
        check("lk_stall_pre", 32'(core_stall), 32'd0);
        tick();
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 12'h000;
        mid();
        check("lk_stall", 32'(core_stall), 32'd1);
        check("lk_if_rvalid", 32'(if_rvalid), 32'd1);
        check("lk_if_rdata", if_rdata, 32'hC0DE0001);
        check("lk_if_refused", 32'(if_gnt), 32'd0);
        check("lk_ld_gnt", 32'(ld_gnt), 32'd1);
        tick();
        ld_req = 1'b0;
        mid();
        check("lk_if_refused2", 32'(if_gnt), 32'd0);
        check("lk_ld_rvalid", 32'(ld_rvalid), 32'd1);
        check("lk_ld_rdata", ld_rdata, 32'hC0DE0000);
        check("lk_if_rvalid0", 32'(if_rvalid), 32'd0);
        tick();
        ld_lock = 1'b0;
        mid();
        check("ul_stall_still", 32'(core_stall), 32'd1);
        check("ul_if_refused", 32'(if_gnt), 32'd0);
        tick();
        mid();
        check("ul_stall", 32'(core_stall), 32'd0);
        check("ul_if_gnt", 32'(if_gnt), 32'd1);
        check("ul_addr", 32'(mem_addr), 32'h004);
        tick();
        if_req = 1'b0;
        mid();
        check("ul_if_rvalid", 32'(if_rvalid), 32'd1);
        check("ul_if_rdata", if_rdata, 32'hC0DE0001);
        tick();

        // ---------------- Reset mid-transaction ----------------
        ld_lock = 1'b1; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 12'h008;
        mid();
        check("mr_gnt0", 32'(ld_gnt), 32'd1);
        tick();
        ld_addr = 12'h004;
        mid();
        check("mr_stall", 32'(core_stall), 32'd1);
        check("mr_gnt1", 32'(ld_gnt), 32'd1);
        tick();
        idle_inputs();
        rst_n = 1'b0;
        mid();
        check("mr_ld_rvalid", 32'(ld_rvalid), 32'd0);
        check("mr_ld_rdata", ld_rdata, 32'h0);
        check("mr_if_rvalid", 32'(if_rvalid), 32'd0);
        check("mr_stall0", 32'(core_stall), 32'd0);
        check("mr_err", 32'(ld_err), 32'd0);
        check("mr_addr", 32'(mem_addr), 32'h000);
        tick();
        rst_n = 1'b1;
        if_req = 1'b1; if_addr = 12'h000;
        mid();
        check("mr_arb_if_gnt", 32'(if_gnt), 32'd1);
        check("mr_arb_stall", 32'(core_stall), 32'd0);
        check("mr_ld_rvalid2", 32'(ld_rvalid), 32'd0);
        tick();
        if_req = 1'b0;
        mid();
        check("mr_if_rvalid2", 32'(if_rvalid), 32'd1);
        check("mr_if_rdata2", if_rdata, 32'hC0DE0000);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "time limit");
    end

endmodule
